// File: rtl/icache_pkg.sv
// ============================================================================
// Module      : icache_pkg
// Description : Shared types and constants for the direct-mapped instruction cache.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package icache_pkg;

  localparam int BLOCK_ADDR_W    = 6;
  localparam int BLOCK_BYTES     = 16;
  localparam int WORD_W          = 32;
  localparam int BLOCK_W         = BLOCK_BYTES * 8;
  localparam int WORDS_PER_BLOCK = BLOCK_W / WORD_W;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_READ = 2'd1,
    UPDATE   = 2'd2
  } state_t;

  // Tag is held at full block-address width so any INDEX_W split fits.
  typedef struct packed {
    logic                    valid;
    logic [BLOCK_ADDR_W-1:0] tag;
    logic [BLOCK_W-1:0]      data;
  } line_t;

endpackage

`default_nettype wire

// File: rtl/icache_mem_if.sv
// ============================================================================
// Module      : icache_mem_if
// Description : Block-read handshake between the cache (master) and instruction memory (slave).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface icache_mem_if;
  import icache_pkg::*;

  logic                    mem_read;
  logic [BLOCK_ADDR_W-1:0] mem_address;
  logic [BLOCK_W-1:0]      mem_readinst;
  logic                    mem_busywait;

  modport master (
    output mem_read,
    output mem_address,
    input  mem_readinst,
    input  mem_busywait
  );

  modport slave (
    input  mem_read,
    input  mem_address,
    output mem_readinst,
    output mem_busywait
  );

endinterface

`default_nettype wire

// File: rtl/icache_word_select.sv
// ============================================================================
// Module      : icache_word_select
// Description : Picks one 32-bit word out of a 128-bit cache block by word offset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module icache_word_select
  import icache_pkg::*;
(
  input  wire logic [BLOCK_W-1:0] block,
  input  wire logic [1:0]         offset,
  output logic      [WORD_W-1:0]  word
);

  logic [WORD_W-1:0] w_words [WORDS_PER_BLOCK];

  for (genvar g = 0; g < WORDS_PER_BLOCK; g++) begin : g_words
    assign w_words[g] = block[g*WORD_W +: WORD_W];
  end

  assign word = w_words[offset];

endmodule

`default_nettype wire

// File: rtl/instruction_cache.sv
// ============================================================================
// Module      : instruction_cache
// Description : Direct-mapped read-only instruction cache; hits same cycle, misses
//               stall the CPU while one 16-byte block is fetched.
//               Optional hit/miss counters enabled by macro ICACHE_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instruction_cache
  import icache_pkg::*;
#(
  parameter int INDEX_W = 3,
  parameter int TAG_W   = 6 - INDEX_W
) (
  input  wire logic        clock,
  input  wire logic        reset_n,
  input  wire logic        read,
  input  wire logic [9:0]  address,
  output logic      [31:0] instruction,
  output logic             busywait,
  icache_mem_if.master     mem,
  output logic      [15:0] hit_count,
  output logic      [15:0] miss_count
);

  localparam int NUM_LINES = 2 ** INDEX_W;

  state_t                  r_state;
  logic [BLOCK_ADDR_W-1:0] r_miss_addr;
  logic                    r_mem_read;
  logic [NUM_LINES-1:0]    r_valid;
  logic [TAG_W-1:0]        r_tag  [NUM_LINES];
  logic [BLOCK_W-1:0]      r_data [NUM_LINES];

  logic [TAG_W-1:0]   w_tag;
  logic [INDEX_W-1:0] w_index;
  logic [1:0]         w_offset;
  logic [1:0]         w_unused_byte_sel;
  logic [INDEX_W-1:0] w_fill_index;
  logic               w_fill;
  line_t              w_line;
  logic               w_hit;
  logic [WORD_W-1:0]  w_word;

  assign w_tag             = address[9 -: TAG_W];
  assign w_index           = address[4 +: INDEX_W];
  assign w_offset          = address[3:2];
  assign w_unused_byte_sel = address[1:0];

  assign w_fill_index = r_miss_addr[INDEX_W-1:0];
  assign w_fill       = (r_state == MEM_READ) && !mem.mem_busywait;

  assign w_line.valid = r_valid[w_index];
  assign w_line.tag   = BLOCK_ADDR_W'(r_tag[w_index]);
  assign w_line.data  = r_data[w_index];

  assign w_hit = read && w_line.valid && (w_line.tag == BLOCK_ADDR_W'(w_tag));

  icache_word_select u_word_select (
    .block  (w_line.data),
    .offset (w_offset),
    .word   (w_word)
  );

  assign instruction     = w_hit ? w_word : '0;
  assign busywait        = (r_state != IDLE) || (read && !w_hit);
  assign mem.mem_read    = r_mem_read;
  assign mem.mem_address = r_miss_addr;

  // mem_read is raised on entry to MEM_READ so memory sees it a full cycle early.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_miss_addr <= '0;
      r_mem_read  <= 1'b0;
      r_valid     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (read && !w_hit) begin
            r_miss_addr <= {w_tag, w_index};
            r_mem_read  <= 1'b1;
            r_state     <= MEM_READ;
          end
        end
        MEM_READ: begin
          if (!mem.mem_busywait) begin
            r_valid[w_fill_index] <= 1'b1;
            r_mem_read            <= 1'b0;
            r_state               <= UPDATE;
          end
        end
        UPDATE: begin
          r_state <= IDLE;
        end
        default: begin
          r_mem_read <= 1'b0;
          r_state    <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (w_fill) begin
      r_tag[w_fill_index]  <= r_miss_addr[BLOCK_ADDR_W-1 -: TAG_W];
      r_data[w_fill_index] <= mem.mem_readinst;
    end
  end

`ifdef ICACHE_STATS_EN
  logic [15:0] r_hit_count;
  logic [15:0] r_miss_count;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else if (r_state == IDLE) begin
      if (w_hit && (r_hit_count != 16'hFFFF)) begin
        r_hit_count <= r_hit_count + 16'd1;
      end
      if (read && !w_hit && (r_miss_count != 16'hFFFF)) begin
        r_miss_count <= r_miss_count + 16'd1;
      end
    end
  end

  assign hit_count  = r_hit_count;
  assign miss_count = r_miss_count;
`else
  assign hit_count  = 16'h0;
  assign miss_count = 16'h0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_instruction_cache.sv
// ============================================================================
// Module      : tb_instruction_cache
// Description : Scoreboard bench for instruction_cache with a 2-busy-cycle memory model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instruction_cache;
  import icache_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        read = 1'b0;
  logic [9:0]  address = '0;
  logic [31:0] instruction;
  logic        busywait;
  logic [15:0] hit_count;
  logic [15:0] miss_count;

  icache_mem_if mem_if ();

  instruction_cache dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .read        (read),
    .address     (address),
    .instruction (instruction),
    .busywait    (busywait),
    .mem         (mem_if.master),
    .hit_count   (hit_count),
    .miss_count  (miss_count)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  logic [31:0] q_instr [$];
  logic [5:0]  q_mem   [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory: word w of block b = {16'hC0DE, 2'b00, b, 6'b0, w}; two busy cycles per request.
  initial begin
    bit active = 0;
    int cnt = 0;
    mem_if.mem_busywait = 1'b0;
    mem_if.mem_readinst = '0;
    forever begin
      @(negedge clock);
      if (!reset_n || !mem_if.mem_read) begin
        active = 0;
        mem_if.mem_busywait = 1'b0;
      end else if (!active) begin
        active = 1;
        cnt = 2;
        mem_if.mem_busywait = 1'b1;
      end else begin
        cnt--;
        if (cnt == 0) begin
          for (int w = 0; w < 4; w++)
            mem_if.mem_readinst[32*w +: 32] = {16'hC0DE, 2'b00, mem_if.mem_address, 6'b0, 2'(w)};
          mem_if.mem_busywait = 1'b0;
        end
      end
    end
  end

  // Monitor: pops expected words on accepted fetches and expected block addresses on new requests.
  initial begin
    logic prev_mem_read = 1'b0;
    logic [31:0] e32;
    logic [5:0]  e6;
    forever begin
      @(negedge clock);
      if (reset_n && read && !busywait) begin
        if (q_instr.size() == 0) begin
          check("unexpected_fetch", instruction, 32'hxxxx_xxxx);
        end else begin
          e32 = q_instr.pop_front();
          check("instr", instruction, e32);
        end
      end
      if (mem_if.mem_read && !prev_mem_read) begin
        if (q_mem.size() == 0) begin
          check("unexpected_mem_read", {26'b0, mem_if.mem_address}, 32'hFFFF_FFFF);
        end else begin
          e6 = q_mem.pop_front();
          check("mem_address", {26'b0, mem_if.mem_address}, {26'b0, e6});
        end
      end
      prev_mem_read = mem_if.mem_read;
    end
  end

  task automatic wait_accept(input string name);
    for (int i = 0; i < 64; i++) begin
      @(negedge clock);
      if (!busywait) return;
    end
    check({name, "_timeout"}, 32'd1, 32'd0);
  endtask

  task automatic wait_mem_read(input string name);
    for (int i = 0; i < 64; i++) begin
      @(negedge clock);
      if (mem_if.mem_read) return;
    end
    check({name, "_timeout"}, 32'd1, 32'd0);
  endtask

  task automatic fetch(input logic [9:0] a, input logic [31:0] exp, input bit miss,
                       input logic [5:0] blk);
    q_instr.push_back(exp);
    if (miss) q_mem.push_back(blk);
    @(posedge clock);
    #1;
    read    = 1'b1;
    address = a;
    #1;
    check("busy_on_issue", {31'b0, busywait}, {31'b0, miss});
    wait_accept("fetch");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d", total);
    $fatal(1);
  end

  initial begin
    logic [15:0] exp_hits;
    logic [15:0] exp_misses;

    repeat (3) @(posedge clock);
    #1;
    check("rst_busywait", {31'b0, busywait}, 32'd0);
    check("rst_mem_read", {31'b0, mem_if.mem_read}, 32'd0);
    check("rst_mem_addr", {26'b0, mem_if.mem_address}, 32'd0);
    check("rst_instr", instruction, 32'd0);
    check("rst_hits", {16'b0, hit_count}, 32'd0);
    check("rst_misses", {16'b0, miss_count}, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;

    // Cold miss then same-block hits.
    fetch(10'h000, 32'hC0DE_0000, 1'b1, 6'h00);
    fetch(10'h004, 32'hC0DE_0001, 1'b0, 6'h00);
    fetch(10'h008, 32'hC0DE_0002, 1'b0, 6'h00);
    fetch(10'h00C, 32'hC0DE_0003, 1'b0, 6'h00);
    @(posedge clock);
    #1;
    read = 1'b0;
`ifdef ICACHE_STATS_EN
    exp_hits   = 16'd4;
    exp_misses = 16'd1;
`else
    exp_hits   = 16'd0;
    exp_misses = 16'd0;
`endif
    #1;
    check("hit_count", {16'b0, hit_count}, {16'b0, exp_hits});
    check("miss_count", {16'b0, miss_count}, {16'b0, exp_misses});
    check("idle_busywait", {31'b0, busywait}, 32'd0);
    check("idle_instr", instruction, 32'd0);
    check("idle_mem_read", {31'b0, mem_if.mem_read}, 32'd0);

    // Conflict misses on index 0.
    fetch(10'h080, 32'hC0DE_0800, 1'b1, 6'h08);
    fetch(10'h084, 32'hC0DE_0801, 1'b0, 6'h00);
    fetch(10'h000, 32'hC0DE_0000, 1'b1, 6'h00);

    // Address change during MEM_READ: block 1 is still filled, then 0x3F0 misses.
    q_instr.push_back(32'hC0DE_3F00);
    q_mem.push_back(6'h01);
    q_mem.push_back(6'h3F);
    @(posedge clock);
    #1;
    address = 10'h010;
    wait_mem_read("switch");
    address = 10'h3F0;
    wait_accept("switch");
    fetch(10'h014, 32'hC0DE_0101, 1'b0, 6'h00);
    fetch(10'h3FC, 32'hC0DE_3F03, 1'b0, 6'h00);

    // Reset during MEM_READ abandons the fill and clears all valid bits.
    q_mem.push_back(6'h02);
    @(posedge clock);
    #1;
    address = 10'h020;
    wait_mem_read("rst_fill");
    #2;
    reset_n = 1'b0;
    read    = 1'b0;
    #1;
    check("rstfill_mem_read", {31'b0, mem_if.mem_read}, 32'd0);
    check("rstfill_busywait", {31'b0, busywait}, 32'd0);
    check("rstfill_mem_addr", {26'b0, mem_if.mem_address}, 32'd0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    fetch(10'h000, 32'hC0DE_0000, 1'b1, 6'h00);
    fetch(10'h020, 32'hC0DE_0200, 1'b1, 6'h02);

    @(posedge clock);
    #1;
    read = 1'b0;
    repeat (2) @(negedge clock);
    check("instr_queue_empty", q_instr.size(), 32'd0);
    check("mem_queue_empty", q_mem.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/instruction_cache.md
Name: instruction_cache

Overview:
- Direct-mapped instruction cache between the CPU fetch stage and the 64-block x 16-byte instruction memory.
- Acts as the initiator of the memory's block-read handshake (read/address/readinst/busywait).
- Serves 32-bit instructions to the CPU. A hit returns the word in the same cycle. A miss stalls the CPU through busywait while one 16-byte block is fetched.

Parameters:
- INDEX_W, 3, index bits; number of cache lines = 2**INDEX_W (default 8).
- TAG_W, 6-INDEX_W, tag bits; the block address is fixed at 6 bits, so TAG_W = 3 by default.

Ports:
- clock  input  1  system clock; all state updates on posedge.
- reset_n  input  1  asynchronous, active-low reset.
- read  input  1  CPU fetch request.
- address  input  10  CPU byte address (PC). Bits [1:0] are ignored.
- instruction  output  32  fetched instruction word.
- busywait  output  1  CPU stall request.
- mem_read  output  1  block read request to instruction memory.
- mem_address  output  6  block address to instruction memory.
- mem_readinst  input  128  block returned by memory; byte k is at [8k+7:8k].
- mem_busywait  input  1  memory busy flag.
- hit_count  output  16  hit counter (see Optional Feature).
- miss_count  output  16  miss counter (see Optional Feature).

Behaviour:
- Address split: tag = address[9:10-TAG_W]; index = address[3+INDEX_W:4]; word offset = address[3:2].
- Storage per line: valid bit, TAG_W-bit tag, 128-bit data.
- Word w of a line is data[32w+31:32w].
- hit = read AND valid[index] AND (tag[index] == address tag). This is combinational.
- instruction = selected word when hit, else 32'h0. It is combinational.
- States: IDLE, MEM_READ, UPDATE. Encoding is 2 bits.
- IDLE:
  - busywait = read AND NOT hit.
  - On a posedge with read AND NOT hit: latch the miss block address {tag, index} into miss_addr and go to MEM_READ.
- MEM_READ:
  - mem_read = 1, mem_address = miss_addr, busywait = 1.
  - On a posedge with mem_busywait == 0: capture mem_readinst into line miss_addr[INDEX_W-1:0], set its tag, set valid = 1, go to UPDATE.
  - The state is entered with mem_read already high, so memory raises mem_busywait before the next edge. The first edge in MEM_READ therefore never sees a stale low.
- UPDATE:
  - mem_read = 0, busywait = 1.
  - Next posedge goes to IDLE.
  - In IDLE the current address is re-evaluated and the now-filled line hits.
- Miss penalty: 1 cycle (IDLE to MEM_READ) + memory busy cycles + 1 (UPDATE). Busywait falls combinationally in the IDLE cycle that follows UPDATE.
- In IDLE, mem_read = 0 and mem_address = miss_addr, which holds its last value.
- A change of address while busywait is high is ignored. The fill always targets the latched miss_addr.
- read low in IDLE: busywait = 0, instruction = 0, no memory request.
- read falling during MEM_READ: the fill still completes.
- Conflict miss (same index, different tag) overwrites the line. There is no write-back, because the cache is read-only.
- Reset (asynchronous, any state):
  - state goes to IDLE and all valid bits clear.
  - miss_addr = 0, mem_read = 0, busywait = 0 (with read low), instruction = 0, counters = 0.
  - Tags and data need no reset.
  - A memory access in flight at reset is abandoned. Its response is ignored because the state is IDLE.

Optional Feature:
- Macro ICACHE_STATS_EN.
- Defined:
  - hit_count increments on each posedge in IDLE with read AND hit.
  - miss_count increments on each posedge taking IDLE to MEM_READ.
  - Both counters saturate at 16'hFFFF and clear on reset.
- Undefined: both ports are tied to 16'h0 and no counter flops exist.

Decomposition:
- Shared package icache_pkg holds:
  - state enum (IDLE, MEM_READ, UPDATE);
  - BLOCK_ADDR_W = 6, BLOCK_BYTES = 16, WORD_W = 32;
  - line typedef {valid, tag, data}.
- One natural sub-module, icache_word_select: a 128-to-32 multiplexer keyed by the word offset. The FSM and line storage stay in the top module.

Test Plan:
- Cold miss: memory block 0 = words W0..W3; read = 1, address = 10'h000. Required response:
  - busywait = 1 immediately.
  - mem_read = 1 and mem_address = 6'h00 from the next cycle.
  - After mem_busywait falls plus UPDATE, busywait = 0 and instruction = W0.
- Same-block hits: address 10'h004, 10'h008, 10'h00C -> W1, W2, W3, each in the same cycle with busywait = 0 and mem_read never asserted.
- Conflict miss: address 10'h080 (tag 1, index 0) -> miss with mem_address = 6'h08. Returning to 10'h000 then misses again with mem_address = 6'h00.
- Address change mid-miss: miss at 10'h010, then address switches to 10'h3F0 during MEM_READ. Required response:
  - the line for block 6'h01 is filled;
  - afterwards 10'h3F0 misses with mem_address = 6'h3F.
- Reset mid-fill: assert reset_n = 0 during MEM_READ. Required response:
  - mem_read = 0 and the state is IDLE immediately;
  - after release, 10'h000 misses again because valid was cleared.
- With ICACHE_STATS_EN: 1 cold miss followed by 3 hits -> miss_count = 1, hit_count = 4 (the post-fill fetch counts as a hit). Without the macro, both counters read 0.
